// File: rtl/pigro_wb_pkg.sv
// Shared definitions for the PIGRO writeback/commit stage.
// Holds the opcode encodings, the writeback class enum, the load-size
// constants, the buffer entry type and the opcode classifier.
package pigro_wb_pkg;

  // Default widths of the stored entry; the top-level parameters default to these.
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 4;
  localparam int WB_PC_W   = 5;
  localparam int WB_OP_W   = 5;

  // Opcode encodings of the PIGRO ISA.
  localparam logic [WB_OP_W-1:0] OP_NOP  = 5'h00;
  localparam logic [WB_OP_W-1:0] OP_ADD  = 5'h01;
  localparam logic [WB_OP_W-1:0] OP_SUB  = 5'h02;
  localparam logic [WB_OP_W-1:0] OP_AND  = 5'h03;
  localparam logic [WB_OP_W-1:0] OP_OR   = 5'h04;
  localparam logic [WB_OP_W-1:0] OP_XOR  = 5'h05;
  localparam logic [WB_OP_W-1:0] OP_SLL  = 5'h06;
  localparam logic [WB_OP_W-1:0] OP_SRL  = 5'h07;
  localparam logic [WB_OP_W-1:0] OP_ARSH = 5'h08;
  localparam logic [WB_OP_W-1:0] OP_LDW  = 5'h09;
  localparam logic [WB_OP_W-1:0] OP_STR  = 5'h0A;

  // Load sizes; encoding 3 behaves as a word.
  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  typedef enum logic [2:0] {
    WB_NONE    = 3'd0,
    WB_ALU     = 3'd1,
    WB_LOAD    = 3'd2,
    WB_STORE   = 3'd3,
    WB_ILLEGAL = 3'd4
  } wb_class_e;

  // Data is stored already aligned/extended, so nothing follows the buffer.
  typedef struct packed {
    logic [WB_PC_W-1:0]   pc;
    logic [WB_OP_W-1:0]   opcode;
    logic [WB_ADDR_W-1:0] dest;
    logic                 we;
    logic [WB_DATA_W-1:0] data;
    logic                 illegal;
  } wb_entry_t;

  function automatic wb_class_e wb_classify(input logic [WB_OP_W-1:0] op);
    wb_class_e cls;
    if (op == OP_NOP) begin
      cls = WB_NONE;
    end else if (op <= OP_ARSH) begin
      cls = WB_ALU;
    end else if (op == OP_LDW) begin
      cls = WB_LOAD;
    end else if (op == OP_STR) begin
      cls = WB_STORE;
    end else begin
      cls = WB_ILLEGAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pigro_wb_commit_if.sv
// Bus bundle between the memory stage, the writeback/commit stage and the
// register file write port.
// slave  : view of the commit stage (takes in_* and rf_ready, drives the rest).
// master : view of the surrounding pipeline/RF.
interface pigro_wb_commit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 5,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_alu;
  logic [DATA_W-1:0]    in_lmd;
  logic [PC_W-1:0]      in_pc;
  logic [OP_W-1:0]      in_opcode;
  logic [ADDR_W-1:0]    in_dest;
  logic [1:0]           in_ld_size;
  logic                 in_ld_signed;
  logic [OFF_W-1:0]     in_byte_off;
  logic                 rf_we;
  logic                 rf_ready;
  logic [ADDR_W-1:0]    rf_addr;
  logic [DATA_W-1:0]    rf_data;
  logic [PC_W-1:0]      out_pc;
  logic [OP_W-1:0]      out_opcode;
  logic                 fwd_valid;
  logic [ADDR_W-1:0]    fwd_addr;
  logic [DATA_W-1:0]    fwd_data;
  logic [2**ADDR_W-1:0] busy_mask;
  logic [CNT_W-1:0]     retire_count;
  logic                 illegal;

  modport slave (
    input  in_valid, in_alu, in_lmd, in_pc, in_opcode, in_dest,
           in_ld_size, in_ld_signed, in_byte_off, rf_ready,
    output in_ready, rf_we, rf_addr, rf_data, out_pc, out_opcode,
           fwd_valid, fwd_addr, fwd_data, busy_mask, retire_count, illegal
  );

  modport master (
    output in_valid, in_alu, in_lmd, in_pc, in_opcode, in_dest,
           in_ld_size, in_ld_signed, in_byte_off, rf_ready,
    input  in_ready, rf_we, rf_addr, rf_data, out_pc, out_opcode,
           fwd_valid, fwd_addr, fwd_data, busy_mask, retire_count, illegal
  );
endinterface

// File: rtl/pigro_load_align.sv
// Combinational load alignment: picks a byte/half/word lane out of the raw
// load data and sign- or zero-extends it to DATA_W.
// lmd_i    : raw memory data
// size_i   : 0 byte, 1 half, 2/3 word
// signed_i : 1 sign-extend, 0 zero-extend
// off_i    : byte offset (bit 0 ignored for halves, all ignored for words)
// data_o   : aligned, extended result
module pigro_load_align
  import pigro_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] lmd_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [DATA_W-1:0] data_o
);
  localparam int IDX_W = OFF_W + 3;

  logic [IDX_W-1:0] byte_lo_s;
  logic [IDX_W-1:0] half_lo_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;

  // Bit position of the lane; a half lane is the byte lane with offset bit 0 cleared.
  assign byte_lo_s = {off_i, 3'b000};
  assign half_lo_s = byte_lo_s & ~(IDX_W'(8));
  assign byte_s    = lmd_i[byte_lo_s +: 8];
  assign half_s    = lmd_i[half_lo_s +: 16];

  // Lane selection and extension.
  always_comb begin
    data_o = lmd_i;
    case (size_i)
      LD_BYTE: data_o = {{(DATA_W - 8){signed_i & byte_s[7]}}, byte_s};
      LD_HALF: data_o = {{(DATA_W - 16){signed_i & half_s[15]}}, half_s};
      LD_WORD: data_o = lmd_i;
      default: data_o = lmd_i;
    endcase
  end
endmodule

// File: rtl/pigro_wb_commit.sv
// PIGRO writeback/commit stage.
// A 2-entry FIFO decouples the memory stage from RF backpressure. Entries are
// classified and their write data finalised at push; the head entry drives the
// RF write port, the forwarding outputs and out_pc/out_opcode.
// clk, rst : clock, synchronous active-high reset
// bus      : memory-stage inputs, RF write port, forwarding/hazard outputs,
//            retire counter and illegal-retire pulse
module pigro_wb_commit
  import pigro_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int PC_W   = WB_PC_W,
  parameter int OP_W   = WB_OP_W,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  pigro_wb_commit_if.slave bus
);
  localparam int BUSY_W = 2 ** ADDR_W;

  wb_entry_t         entries_q [2];
  wb_entry_t         entries_d [2];
  logic [1:0]        valid_q, valid_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [CNT_W-1:0]  retire_q, retire_d;

  wb_entry_t         new_entry_s;
  wb_entry_t         head_s;
  wb_class_e         cls_s;
  logic [DATA_W-1:0] aligned_s;
  logic              head_valid_s;
  logic              push_s;
  logic              pop_s;
  logic              rf_we_s;
  logic [BUSY_W-1:0] busy_s;

  pigro_load_align #(.DATA_W(DATA_W)) u_align (
    .lmd_i    (bus.in_lmd),
    .size_i   (bus.in_ld_size),
    .signed_i (bus.in_ld_signed),
    .off_i    (bus.in_byte_off),
    .data_o   (aligned_s)
  );

  // Build the entry to be pushed; class and write data are fixed here.
  always_comb begin
    cls_s              = wb_classify(bus.in_opcode);
    new_entry_s        = '0;
    new_entry_s.pc     = bus.in_pc;
    new_entry_s.opcode = bus.in_opcode;
    new_entry_s.dest   = bus.in_dest;
    case (cls_s)
      WB_ALU: begin
        new_entry_s.we   = 1'b1;
        new_entry_s.data = bus.in_alu;
      end
      WB_LOAD: begin
        new_entry_s.we   = 1'b1;
        new_entry_s.data = aligned_s;
      end
      WB_ILLEGAL: new_entry_s.illegal = 1'b1;
      default:    new_entry_s.we      = 1'b0;
    endcase
  end

  // Everything head-driven is masked while reset is held so a pending write
  // can never be committed during a flush.
  assign head_s       = entries_q[rd_ptr_q];
  assign head_valid_s = valid_q[rd_ptr_q] & ~rst;
  assign rf_we_s      = head_valid_s & head_s.we;
  assign push_s       = bus.in_valid & bus.in_ready;
  assign pop_s        = head_valid_s & (~head_s.we | bus.rf_ready);

  // FIFO pointer, valid, count and retire-counter next state.
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    retire_d  = retire_q;
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ~rd_ptr_q;
      retire_d          = retire_q + CNT_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // A push never targets the slot being popped: with count 1 the pointers differ.
    if (push_s) begin
      entries_d[wr_ptr_q] = new_entry_s;
      valid_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d            = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q[0] <= '0;
      entries_q[1] <= '0;
      valid_q      <= 2'b00;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      retire_q     <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      retire_q  <= retire_d;
    end
  end

  // One-hot destinations of every buffered writing entry.
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < 2; i++) begin
      busy_s = busy_s | (BUSY_W'(valid_q[i] & entries_q[i].we & ~rst) << entries_q[i].dest);
    end
  end

  assign bus.in_ready     = ~rst & (count_q != 2'd2);
  assign bus.rf_we        = rf_we_s;
  assign bus.rf_addr      = head_valid_s ? head_s.dest : '0;
  assign bus.rf_data      = head_valid_s ? head_s.data : '0;
  assign bus.fwd_valid    = rf_we_s;
  assign bus.fwd_addr     = rf_we_s ? head_s.dest : '0;
  assign bus.fwd_data     = rf_we_s ? head_s.data : '0;
  assign bus.out_pc       = head_valid_s ? head_s.pc : '0;
  assign bus.out_opcode   = head_valid_s ? head_s.opcode : '0;
  assign bus.busy_mask    = busy_s;
  assign bus.retire_count = rst ? '0 : retire_q;
  assign bus.illegal      = pop_s & head_s.illegal;
endmodule
